vga_coord_gen: RTL

Raster timing and coordinate generator for the 1280x1024 @ 60 Hz display path (108 MHz pixel clock). Produces the pixel coordinate pair (`VGA_horzCoord`, `VGA_vertCoord`) that feeds the per-pixel glyph and condition decoders downstream, e.g. slash, digit and grid-line conditions. It also produces the sync, active-video and line/frame markers those stages and the colour mux need. All outputs are registered and mutually aligned, so downstream combinational decoders see glitch-free, consistent coordinates.

---
 rtl/vga_if.sv | 19 +
 rtl/vga_coord_gen.sv | 55 +++++
 2 files changed

// File: rtl/vga_if.sv
// vga_if: pixel-advance enable in, raster coordinates and timing markers out
interface vga_if;
  logic CE;
  logic [11:0] VGA_horzCoord;
  logic [11:0] VGA_vertCoord;
  logic VGA_HS;
  logic VGA_VS;
  logic VGA_active;
  logic VGA_lineStart;
  logic VGA_frameStart;
  modport master (
    input  CE,
    output VGA_horzCoord, VGA_vertCoord, VGA_HS, VGA_VS, VGA_active, VGA_lineStart, VGA_frameStart
  );
  modport slave (
    output CE,
    input  VGA_horzCoord, VGA_vertCoord, VGA_HS, VGA_VS, VGA_active, VGA_lineStart, VGA_frameStart
  );
endinterface

// File: rtl/vga_coord_gen.sv
// vga_coord_gen: raster counters with registered sync, active-video and line/frame markers
module vga_coord_gen #(
  parameter int H_VISIBLE = 1280,
  parameter int H_FP = 48,
  parameter int H_SYNC = 112,
  parameter int H_BP = 248,
  parameter int V_VISIBLE = 1024,
  parameter int V_FP = 1,
  parameter int V_SYNC = 3,
  parameter int V_BP = 38,
  parameter logic SYNC_POL = 1'b1
) (
  input logic CLK_VGA,
  input logic RESET,
  vga_if.master vga
);
  localparam logic [11:0] H_LAST = 12'(H_VISIBLE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [11:0] V_LAST = 12'(V_VISIBLE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [11:0] H_VIS = 12'(H_VISIBLE);
  localparam logic [11:0] V_VIS = 12'(V_VISIBLE);
  localparam logic [11:0] HS_ON = 12'(H_VISIBLE + H_FP);
  localparam logic [11:0] HS_OFF = 12'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [11:0] VS_ON = 12'(V_VISIBLE + V_FP);
  localparam logic [11:0] VS_OFF = 12'(V_VISIBLE + V_FP + V_SYNC);
  logic [11:0] h_nxt, v_nxt;
  logic h_wrap, v_wrap;
  always_comb begin
    h_wrap = vga.VGA_horzCoord == H_LAST;
    v_wrap = h_wrap && vga.VGA_vertCoord == V_LAST;
    h_nxt = h_wrap ? 12'd0 : vga.VGA_horzCoord + 12'd1;
    v_nxt = v_wrap ? 12'd0 : vga.VGA_vertCoord + {11'd0, h_wrap};
  end
  // decodes use next-state coordinates so they land in the same cycle as the coords
  always_ff @(posedge CLK_VGA)
    if (RESET) begin
      vga.VGA_horzCoord <= '0;
      vga.VGA_vertCoord <= '0;
      vga.VGA_HS <= ~SYNC_POL;
      vga.VGA_VS <= ~SYNC_POL;
      vga.VGA_active <= 1'b1;
      vga.VGA_lineStart <= 1'b0;
      vga.VGA_frameStart <= 1'b0;
    end else if (vga.CE) begin
      vga.VGA_horzCoord <= h_nxt;
      vga.VGA_vertCoord <= v_nxt;
      vga.VGA_HS <= (h_nxt >= HS_ON && h_nxt < HS_OFF) ? SYNC_POL : ~SYNC_POL;
      vga.VGA_VS <= (v_nxt >= VS_ON && v_nxt < VS_OFF) ? SYNC_POL : ~SYNC_POL;
      vga.VGA_active <= h_nxt < H_VIS && v_nxt < V_VIS;
      vga.VGA_lineStart <= h_wrap;
      vga.VGA_frameStart <= v_wrap;
    end else begin
      vga.VGA_lineStart <= 1'b0;
      vga.VGA_frameStart <= 1'b0;
    end
endmodule
